// File: rtl/pmp_csr_writer_pkg.sv
// rtl/pmp_csr_writer_pkg.sv - shared PMP encodings, cfg bit positions and writer FSM states
package pmp_csr_writer_pkg;

  // Address-matching modes held in cfg bits A; the entry decoders use the same values
  localparam logic [1:0] PMP_A_OFF   = 2'b00;
  localparam logic [1:0] PMP_A_TOR   = 2'b01;
  localparam logic [1:0] PMP_A_NA4   = 2'b10;
  localparam logic [1:0] PMP_A_NAPOT = 2'b11;

  // Bit positions inside one pmpcfg entry byte
  localparam int CFG_L    = 7;
  localparam int CFG_A_HI = 4;
  localparam int CFG_A_LO = 3;
  localparam int CFG_X    = 2;
  localparam int CFG_W    = 1;
  localparam int CFG_R    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CFG
  } wr_state_e;

  // A locked TOR entry also freezes the pmpaddr of the entry below it
  function automatic logic cfg_tor_locked(input logic [7:0] cfg);
    return cfg[CFG_L] && (cfg[CFG_A_HI:CFG_A_LO] == PMP_A_TOR);
  endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// rtl/pmp_cfg_legalize.sv - WARL and lock legalization of a single pmpcfg entry byte
module pmp_cfg_legalize
  import pmp_csr_writer_pkg::*;
(
  input  logic [7:0] old_cfg,
  input  logic [7:0] wr_cfg,
  output logic [7:0] legal_cfg
);

  // Bits 6:5 are hardwired to zero, so the written values are deliberately dropped
  logic unused_rsvd;
  assign unused_rsvd = ^wr_cfg[6:5];

  // Locked entries keep their old byte; otherwise clear reserved bits and the W-without-R combination
  always_comb begin
    legal_cfg = '0;
    if (old_cfg[CFG_L]) begin
      legal_cfg = old_cfg;
    end else begin
      legal_cfg[CFG_L]               = wr_cfg[CFG_L];
      legal_cfg[CFG_A_HI:CFG_A_LO]   = wr_cfg[CFG_A_HI:CFG_A_LO];
      legal_cfg[CFG_X]               = wr_cfg[CFG_X];
      legal_cfg[CFG_W]               = wr_cfg[CFG_W] & wr_cfg[CFG_R];
      legal_cfg[CFG_R]               = wr_cfg[CFG_R];
    end
  end

endmodule

// File: rtl/pmp_csr_writer.sv
// rtl/pmp_csr_writer.sv - pmpcfg/pmpaddr state owner with serialized, lock-aware CSR writes
module pmp_csr_writer
  import pmp_csr_writer_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              WrValid,
  output logic                              WrReady,
  input  logic                              WrIsCfg,
  input  logic [5:0]                        WrIndex,
  input  logic [XLEN-1:0]                   WrData,
  output logic                              WrDone,
  input  logic                              RdIsCfg,
  input  logic [5:0]                        RdIndex,
  output logic [XLEN-1:0]                   RdData,
  output logic [PMP_ENTRIES*8-1:0]          PMPCfgOut,
  output logic [PMP_ENTRIES*(PA_BITS-2)-1:0] PMPAdrOut
);

  // Storage keeps at least one entry so the arrays stay legal when no entries exist
  localparam int NE  = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
  localparam int AW  = PA_BITS - 2;
  localparam int BPW = XLEN / 8;
  localparam int KW  = $clog2(BPW);
  localparam int IW  = (NE > 1) ? $clog2(NE) : 1;

  logic [7:0]    cfg_q  [NE];
  logic [AW-1:0] addr_q [NE];

  wr_state_e       state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [XLEN-1:0] data_q;
  logic [5:0]      idx_q;
  logic            accept;
  logic            last_byte;

  assign WrReady   = (state_q == ST_IDLE) && !reset;
  assign accept    = WrValid && WrReady;
  assign last_byte = (k_q == KW'(BPW - 1));
  assign WrDone    = !reset && ((state_q == ST_ADDR) || ((state_q == ST_CFG) && last_byte));

  // Writer state, byte counter and the latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        data_q <= WrData;
        idx_q  <= WrIndex;
      end
    end
  end

  // Next-state logic: addr writes take one cycle, cfg writes walk every byte of the register
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = WrIsCfg ? ST_CFG : ST_ADDR;
          k_d     = '0;
        end
      end
      ST_ADDR: state_d = ST_IDLE;
      ST_CFG: begin
        k_d = k_q + KW'(1);
        if (last_byte) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cfg path: one entry byte per cycle through the shared legalizer
  logic [8:0]    cfg_e;
  logic [IW-1:0] cfg_idx;
  logic [7:0]    cfg_old;
  logic [7:0]    cfg_raw;
  logic [7:0]    cfg_legal;
  logic          cfg_odd_skip;
  logic          cfg_we;

  assign cfg_e        = {1'b0, idx_q, 2'b00} + 9'(k_q);
  assign cfg_idx      = cfg_e[IW-1:0];
  assign cfg_old      = cfg_q[cfg_idx];
  assign cfg_raw      = data_q[8*k_q +: 8];
  // On RV64 the odd pmpcfg numbers do not exist; the sequence still runs but stores nothing
  assign cfg_odd_skip = (XLEN == 64) && idx_q[0];
  assign cfg_we       = (state_q == ST_CFG) && !cfg_odd_skip && (32'(cfg_e) < PMP_ENTRIES);

  pmp_cfg_legalize u_legalize (
    .old_cfg   (cfg_old),
    .wr_cfg    (cfg_raw),
    .legal_cfg (cfg_legal)
  );

  // Addr path: blocked by the entry's own lock or by a locked TOR entry directly above
  logic [IW-1:0] addr_idx;
  logic [IW-1:0] next_idx;
  logic          addr_in_range;
  logic          next_in_range;
  logic          addr_locked;
  logic          addr_we;
  logic [AW-1:0] addr_wdata;

  assign addr_idx      = idx_q[IW-1:0];
  assign next_idx      = addr_idx + IW'(1);
  assign addr_in_range = 32'(idx_q) < PMP_ENTRIES;
  assign next_in_range = (32'(idx_q) + 32'd1) < PMP_ENTRIES;
  assign addr_locked   = cfg_q[addr_idx][CFG_L] ||
                         (next_in_range && cfg_tor_locked(cfg_q[next_idx]));
  assign addr_we       = (state_q == ST_ADDR) && addr_in_range && !addr_locked;
  assign addr_wdata    = AW'(data_q);

  // Committed PMP state; reset also discards bytes already written by an abandoned sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (cfg_we)  cfg_q[cfg_idx]   <= cfg_legal;
      if (addr_we) addr_q[addr_idx] <= addr_wdata;
    end
  end

  // Readback: pack the cfg bytes of the selected register, or zero-extend the selected addr
  logic [XLEN-1:0] rd_cfg;
  logic [XLEN-1:0] rd_addr;
  logic [31:0]     rd_e;

  always_comb begin
    rd_cfg = '0;
    rd_e   = '0;
    for (int j = 0; j < BPW; j++) begin
      rd_e = 32'({RdIndex, 2'b00}) + 32'(j);
      if (rd_e < PMP_ENTRIES) rd_cfg[8*j +: 8] = cfg_q[rd_e[IW-1:0]];
    end
  end

  assign rd_addr = (32'(RdIndex) < PMP_ENTRIES) ? XLEN'(addr_q[RdIndex[IW-1:0]]) : '0;
  assign RdData  = RdIsCfg ? rd_cfg : rd_addr;

  generate
    if (PMP_ENTRIES == 0) begin : g_no_entries
      assign PMPCfgOut = '0;
      assign PMPAdrOut = '0;
    end else begin : g_entries
      for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_out
        assign PMPCfgOut[8*i +: 8]   = cfg_q[i];
        assign PMPAdrOut[AW*i +: AW] = addr_q[i];
      end
    end
  endgenerate

endmodule

// File: tb/tb_pmp_csr_writer.sv
// tb/tb_pmp_csr_writer.sv - directed self-checking bench for pmp_csr_writer
module tb_pmp_csr_writer;

  localparam int XLEN = 64;
  localparam int PA_BITS = 56;
  localparam int PMP_ENTRIES = 16;
  localparam int AW = PA_BITS - 2;

  logic                       clk;
  logic                       reset;
  logic                       WrValid;
  logic                       WrReady;
  logic                       WrIsCfg;
  logic [5:0]                 WrIndex;
  logic [XLEN-1:0]            WrData;
  logic                       WrDone;
  logic                       RdIsCfg;
  logic [5:0]                 RdIndex;
  logic [XLEN-1:0]            RdData;
  logic [PMP_ENTRIES*8-1:0]   PMPCfgOut;
  logic [PMP_ENTRIES*AW-1:0]  PMPAdrOut;

  int n_asserts = 0;
  int n_fail = 0;

  pmp_csr_writer #(
    .XLEN        (XLEN),
    .PA_BITS     (PA_BITS),
    .PMP_ENTRIES (PMP_ENTRIES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .WrValid   (WrValid),
    .WrReady   (WrReady),
    .WrIsCfg   (WrIsCfg),
    .WrIndex   (WrIndex),
    .WrData    (WrData),
    .WrDone    (WrDone),
    .RdIsCfg   (RdIsCfg),
    .RdIndex   (RdIndex),
    .RdData    (RdData),
    .PMPCfgOut (PMPCfgOut),
    .PMPAdrOut (PMPAdrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic is_cfg, input logic [5:0] idx, input logic [63:0] exp);
    RdIsCfg = is_cfg;
    RdIndex = idx;
    #1;
    chk(tag, RdData, exp);
  endtask

  // Issues one write, returns cycles from accept to WrDone and how many of them had WrReady low
  task automatic do_write(input logic is_cfg, input logic [5:0] idx, input logic [63:0] data,
                          output int lat, output int ready_low);
    @(negedge clk);
    WrValid = 1'b1;
    WrIsCfg = is_cfg;
    WrIndex = idx;
    WrData  = data;
    #1;
    chk("ready_before_write", WrReady, 1'b1);
    @(posedge clk);
    lat = 0;
    ready_low = 0;
    do begin
      @(negedge clk);
      WrValid = 1'b0;
      lat++;
      #1;
      if (!WrReady) ready_low++;
    end while (!WrDone && lat < 20);
    chk("ready_low_in_done_cycle", WrReady, 1'b0);
    @(negedge clk);
  endtask

  int lat, rlow, done_seen;
  logic [63:0] exp_v;

  initial begin
    reset = 1'b1;
    WrValid = 1'b0;
    WrIsCfg = 1'b0;
    WrIndex = '0;
    WrData = '0;
    RdIsCfg = 1'b0;
    RdIndex = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", WrReady, 1'b0);
    chk("done_in_reset", WrDone, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", WrReady, 1'b1);
    rd("cfg0_reset", 1'b1, 6'd0, 64'h0);
    rd("cfg2_reset", 1'b1, 6'd2, 64'h0);
    for (int i = 0; i < 16; i++) rd("addr_reset", 1'b0, 6'(i), 64'h0);

    // addr write truncates to PA_BITS-2 bits
    do_write(1'b0, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, lat, rlow);
    chk("addr_latency", 64'(lat), 64'd1);
    rd("addr3_trunc", 1'b0, 6'd3, 64'h003F_FFFF_FFFF_FFFF);
    chk("adrout3", 64'(PMPAdrOut[3*AW +: AW]), 64'h003F_FFFF_FFFF_FFFF);

    // cfg legalization: W without R cleared
    do_write(1'b1, 6'd0, 64'h0000_0000_0000_0A02, lat, rlow);
    chk("cfg_latency", 64'(lat), 64'd8);
    chk("cfg_ready_low", 64'(rlow), 64'd8);
    rd("cfg0_legal", 1'b1, 6'd0, 64'h0000_0000_0000_0800);

    // lock entry2 as TOR
    do_write(1'b1, 6'd0, 64'h0000_0000_008F_0800, lat, rlow);
    rd("cfg0_lock", 1'b1, 6'd0, 64'h0000_0000_008F_0800);
    chk("cfgout2", 64'(PMPCfgOut[23:16]), 64'h8F);
    do_write(1'b0, 6'd2, 64'h1234, lat, rlow);
    chk("locked_addr_latency", 64'(lat), 64'd1);
    rd("addr2_locked", 1'b0, 6'd2, 64'h0);
    do_write(1'b0, 6'd1, 64'h5678, lat, rlow);
    rd("addr1_tor_locked", 1'b0, 6'd1, 64'h0);
    do_write(1'b0, 6'd3, 64'hABCD, lat, rlow);
    rd("addr3_open", 1'b0, 6'd3, 64'hABCD);
    chk("adrout3_open", 64'(PMPAdrOut[3*AW +: AW]), 64'hABCD);
    do_write(1'b1, 6'd0, 64'h0000_0000_0000_0800, lat, rlow);
    rd("cfg0_lock_held", 1'b1, 6'd0, 64'h0000_0000_008F_0800);

    // odd pmpcfg on RV64 is a no-op with full latency
    do_write(1'b1, 6'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat, rlow);
    chk("odd_cfg_latency", 64'(lat), 64'd8);
    chk("cfgout_lo_odd", PMPCfgOut[63:0], 64'h0000_0000_008F_0800);
    chk("cfgout_hi_odd", PMPCfgOut[127:64], 64'h0);

    // entries beyond PMP_ENTRIES
    do_write(1'b0, 6'd20, 64'h7777, lat, rlow);
    rd("addr20_oor", 1'b0, 6'd20, 64'h0);
    do_write(1'b1, 6'd4, 64'h1F1F_1F1F_1F1F_1F1F, lat, rlow);
    chk("oor_cfg_latency", 64'(lat), 64'd8);
    rd("cfg4_oor", 1'b1, 6'd4, 64'h0);
    rd("cfg2_untouched", 1'b1, 6'd2, 64'h0);

    // reset in CFG cycle 4 abandons the sequence and clears committed bytes
    @(negedge clk);
    WrValid = 1'b1;
    WrIsCfg = 1'b1;
    WrIndex = 6'd2;
    WrData = 64'h1F1F_1F1F_1F1F_1F1F;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      WrValid = 1'b0;
    end
    rd("cfg2_partial", 1'b1, 6'd2, 64'h0000_0000_001F_1F1F);
    reset = 1'b1;
    #1;
    chk("done_at_reset", WrDone, 1'b0);
    chk("ready_at_reset", WrReady, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_abort", WrReady, 1'b1);
    rd("cfg2_cleared", 1'b1, 6'd2, 64'h0);
    rd("cfg0_cleared", 1'b1, 6'd0, 64'h0);
    rd("addr3_cleared", 1'b0, 6'd3, 64'h0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (WrDone) done_seen++;
    end
    chk("no_done_after_abort", 64'(done_seen), 64'd0);

    // readback during CFG: byte k visible from the cycle after it is processed
    @(negedge clk);
    WrValid = 1'b1;
    WrIsCfg = 1'b1;
    WrIndex = 6'd0;
    WrData = 64'h1F1F_1F1F_1F1F_1F1F;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      WrValid = 1'b0;
      exp_v = 64'h0;
      for (int j = 0; j < c - 1; j++) exp_v[8*j +: 8] = 8'h1F;
      rd("cfg0_progress", 1'b1, 6'd0, exp_v);
      chk("done_progress", WrDone, (c == 8) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    rd("cfg0_full", 1'b1, 6'd0, 64'h1F1F_1F1F_1F1F_1F1F);
    chk("done_cleared", WrDone, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_csr_writer.md
Name: pmp_csr_writer

Overview:
- Write side of the PMP checker: owns the pmpcfg/pmpaddr state consumed by the per-entry address decoders, and applies all privileged-spec WARL and lock rules on CSR writes.
- Accepts CSR writes from the CSR unit over a valid/ready handshake.
- Packed pmpcfg writes are serialized one entry byte per cycle to keep lock logic to a single per-entry checker.
- Exports flat cfg/addr vectors to the PMP checker and provides a combinational CSR readback port.

Parameters:
- XLEN, 64, register width; legal values 32 or 64.
- PA_BITS, 56, physical address width; stored pmpaddr width is PA_BITS-2.
- PMP_ENTRIES, 16, implemented entries; legal values 0, 16 or 64.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- WrValid  in  1  write request valid
- WrReady  out  1  writer idle, request accepted when WrValid&WrReady
- WrIsCfg  in  1  1 = pmpcfgN write, 0 = pmpaddrN write
- WrIndex  in  6  CSR number offset N
- WrData  in  XLEN  write data
- WrDone  out  1  one-cycle pulse, write fully committed
- RdIsCfg  in  1  readback selects pmpcfgN
- RdIndex  in  6  readback CSR offset
- RdData  out  XLEN  readback data (combinational)
- PMPCfgOut  out  PMP_ENTRIES*8  entry i in bits [8i+7:8i]
- PMPAdrOut  out  PMP_ENTRIES*(PA_BITS-2)  entry i packed likewise

Behaviour:
- Reset: all cfg bytes and addrs go to 0; FSM goes to IDLE; WrDone=0; WrReady=0 while reset is high. Reset mid-sequence abandons the sequence; bytes already committed are also cleared.
- FSM states:
  - IDLE: WrReady=1. An accepted addr write goes to ADDR. An accepted cfg write latches WrData/WrIndex, clears byte counter k, and goes to CFG.
  - ADDR: commits one entry; WrDone=1; returns to IDLE. Latency is one cycle after accept.
  - CFG: each cycle processes byte k (entry e = 4*N + k), then k++. On k = XLEN/8-1, asserts WrDone and returns to IDLE. Latency is XLEN/8 cycles (8 when XLEN=64).
- WrReady=0 in ADDR and CFG. WrValid held high is not accepted until IDLE. There is no back-to-back acceptance in the WrDone cycle.
- XLEN=64 with odd N on a cfg write: no state change; still takes the full sequence and pulses WrDone.
- Entries >= PMP_ENTRIES: writes are ignored and reads return 0. With PMP_ENTRIES=0, everything is read-only zero.
- Cfg byte rules:
  - Ignored if the current L(e)=1.
  - Bits 6:5 are stored as 0.
  - W is stored as W&R; the reserved RW=01 combination becomes 00.
  - L, A, X and R are stored as written.
- Addr write rules:
  - Ignored if L(N)=1.
  - Also ignored if N+1 < PMP_ENTRIES and L(N+1)=1 and A(N+1)=TOR(01).
  - Otherwise stores WrData[PA_BITS-3:0]; upper bits are dropped.
- Lock evaluation always uses committed state at the cycle of commit. A cfg write that sets L on byte k does not affect byte k itself, but locks later writes.
- Readback:
  - pmpaddr reads return the zero-extended stored value.
  - pmpcfg reads pack bytes 4N..4N+XLEN/8-1.
  - Reads during CFG see bytes < k already updated and bytes >= k still old.

Decomposition:
- Shared pmp package:
  - Address-mode localparams OFF/TOR/NA4/NAPOT, shared with the decoder.
  - Cfg bit positions L=7, A=4:3, X=2, W=1, R=0.
  - Writer FSM state enum {IDLE, ADDR, CFG}.
- One sub-module, pmp_cfg_legalize: combinational. Takes old byte and new byte and returns the legalized byte, honouring lock. It is reused per cycle by the serializer.

Test Plan:
- After reset: RdData for pmpcfg0 and for pmpaddr0..15 is 0. Then write pmpaddr3=0xFFFF_FFFF_FFFF_FFFF -> pmpaddr3 reads 0x003F_FFFF_FFFF_FFFF (PA_BITS=56). WrDone occurs 1 cycle after accept.
- Write pmpcfg0=0x0000_0000_0000_0A02 -> WrReady is low for 8 cycles and WrDone pulses in the 8th. Entry1 = 0x08 (TOR, no perms). Entry0 = 0x00, because W without R is cleared.
- Write pmpcfg0 byte2=0x8F (L|TOR|XWR) -> then pmpaddr2 write is ignored, pmpaddr1 write is ignored (TOR lock on entry2), pmpaddr3 write is accepted. Rewriting pmpcfg0 byte2=0x00 leaves it at 0x8F.
- Cfg write to pmpcfg1 (odd, XLEN=64) -> all cfg unchanged and WrDone still pulses after 8 cycles.
- Assert reset in CFG cycle 4 of a pmpcfg2=0x1F1F1F1F1F1F1F1F write -> next cycle all cfg are 0, FSM is IDLE, and no WrDone pulse occurs.
- Read pmpcfg0 each cycle during a 0x1F..1F write over 0x00..00 -> byte k reads 0x1F starting the cycle after the sequence's k-th cycle.
